// File: rtl/up5k_clk_rst_led_if.sv
// LED control bundle between the GPIO/enable source and the RGB sink-driver model.
interface up5k_clk_rst_led_if;
  logic             curren;
  logic             rgbleden;
  logic [2:0]       gpio_led;
  logic [2:0]       rgb_n;
  logic [2:0][3:0]  led_ma;

  modport master (
    output curren, rgbleden, gpio_led,
    input  rgb_n, led_ma
  );

  modport slave (
    input  curren, rgbleden, gpio_led,
    output rgb_n, led_ma
  );
endinterface

// File: rtl/up5k_clk_rst_led.sv
// UP5K system control: 48 MHz -> system clock divider, power-on reset stretcher,
// and a digital model of the RGB LED sink driver.
module up5k_clk_rst_led #(
  parameter int unsigned DIV_MODE     = 0,
  parameter logic [7:0]  RST_CNT_MAX  = 8'hFF,
  parameter int unsigned CURRENT_MODE = 1,
  parameter logic [5:0]  RGB0_CURRENT = 6'b000111,
  parameter logic [5:0]  RGB1_CURRENT = 6'b000111,
  parameter logic [5:0]  RGB2_CURRENT = 6'b000111
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 sys_clk,
  output logic                 sys_clk_en,
  output logic                 sys_reset,
  up5k_clk_rst_led_if.slave    led
);

  // CURRENT_MODE only scales the unit of led_ma (0.5 mA vs 1 mA); no logic depends on it.
  if (DIV_MODE > 1) begin : g_bad_div_mode
    $error("DIV_MODE must be 0 or 1");
  end
  if (CURRENT_MODE > 1) begin : g_bad_current_mode
    $error("CURRENT_MODE must be 0 or 1");
  end

  localparam logic [2:0][5:0] RGB_CURRENT = {RGB2_CURRENT, RGB1_CURRENT, RGB0_CURRENT};

  logic [1:0] cnt;
  logic [1:0] cnt_next;
  logic       sys_clk_next;
  logic       tick;
  logic [7:0] rst_cnt;
  logic [2:0] lit;

  always_comb begin
    cnt_next     = cnt + 2'd1;
    sys_clk_next = 1'b0;
    tick         = 1'b0;
    if (DIV_MODE == 0) begin
      if (cnt == 2'd2) begin
        cnt_next     = '0;
        sys_clk_next = 1'b1;
      end
      tick = sys_clk_next;
    end else begin
      sys_clk_next = cnt_next[1];
      tick         = sys_clk_next & ~sys_clk;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      sys_clk    <= 1'b0;
      sys_clk_en <= 1'b0;
    end else begin
      cnt        <= cnt_next;
      sys_clk    <= sys_clk_next;
      sys_clk_en <= tick;
    end
  end

  // Stretcher advances on the same edge that raises sys_clk_en, so tick N lands on edge 3N (mode 0).
  always_ff @(posedge clk) begin
    if (reset) begin
      rst_cnt   <= '0;
      sys_reset <= 1'b1;
    end else if (tick) begin
      if (rst_cnt != RST_CNT_MAX) begin
        rst_cnt   <= rst_cnt + 8'd1;
        sys_reset <= 1'b1;
      end else begin
        sys_reset <= 1'b0;
      end
    end
  end

  always_comb begin
    lit = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      lit[i] = led.curren & led.rgbleden & ~led.gpio_led[i] & (RGB_CURRENT[i] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led.rgb_n  <= '1;
      led.led_ma <= '0;
    end else begin
      led.rgb_n <= ~lit;
      for (int unsigned i = 0; i < 3; i++) begin
        led.led_ma[i] <= lit[i] ? 4'($countones(RGB_CURRENT[i])) : 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_up5k_clk_rst_led.sv
// Bench for up5k_clk_rst_led: three instances (default, DIV_MODE=1, RGB1_CURRENT=0)
// checked through a cycle-tagged scoreboard queue.
module tb_up5k_clk_rst_led;

  logic        clk = 1'b0;
  logic        reset;
  int unsigned cyc = 0;

  logic d0_sys_clk, d0_sys_clk_en, d0_sys_reset;
  logic d1_sys_clk, d1_sys_clk_en, d1_sys_reset;
  logic d2_sys_clk, d2_sys_clk_en, d2_sys_reset;

  up5k_clk_rst_led_if if0 ();
  up5k_clk_rst_led_if if1 ();
  up5k_clk_rst_led_if if2 ();

  up5k_clk_rst_led dut0 (
    .clk(clk), .reset(reset), .sys_clk(d0_sys_clk), .sys_clk_en(d0_sys_clk_en),
    .sys_reset(d0_sys_reset), .led(if0.slave)
  );

  up5k_clk_rst_led #(.DIV_MODE(1)) dut1 (
    .clk(clk), .reset(reset), .sys_clk(d1_sys_clk), .sys_clk_en(d1_sys_clk_en),
    .sys_reset(d1_sys_reset), .led(if1.slave)
  );

  up5k_clk_rst_led #(.RGB1_CURRENT(6'b000000)) dut2 (
    .clk(clk), .reset(reset), .sys_clk(d2_sys_clk), .sys_clk_en(d2_sys_clk_en),
    .sys_reset(d2_sys_reset), .led(if2.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum {D0_CLK, D0_EN, D0_RST, D0_RGB, D0_MA, D1_CLK, D1_EN, D2_RGB, D2_MA} sig_e;
  typedef struct {
    int unsigned cyc;
    sig_e        id;
    logic [11:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic expect_at(input int unsigned c, input sig_e id, input logic [11:0] v);
    exp_t e;
    e.cyc = c;
    e.id  = id;
    e.val = v;
    sb.push_back(e);
  endtask

  function automatic logic [11:0] sample(input sig_e id);
    case (id)
      D0_CLK:  return 12'(d0_sys_clk);
      D0_EN:   return 12'(d0_sys_clk_en);
      D0_RST:  return 12'(d0_sys_reset);
      D0_RGB:  return 12'(if0.rgb_n);
      D0_MA:   return 12'(if0.led_ma);
      D1_CLK:  return 12'(d1_sys_clk);
      D1_EN:   return 12'(d1_sys_clk_en);
      D2_RGB:  return 12'(if2.rgb_n);
      D2_MA:   return 12'(if2.led_ma);
      default: return '0;
    endcase
  endfunction

  // Monitor: every negedge, retire all expectations tagged for this cycle.
  always @(negedge clk) begin
    for (int i = int'(sb.size()) - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        logic [11:0] got;
        got = sample(sb[i].id);
        n_tests++;
        if (sb[i].cyc < cyc) begin
          n_fail++;
          $display("FAIL %s late: tagged cyc=%0d seen at cyc=%0d", sb[i].id.name(), sb[i].cyc, cyc);
        end else if (got !== sb[i].val) begin
          n_fail++;
          $display("FAIL %s cyc=%0d got=%h want=%h", sb[i].id.name(), cyc, got, sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  task automatic goto(input int unsigned n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic set_led(input logic cur, input logic en, input logic [2:0] g);
    if0.curren   = cur;
    if0.rgbleden = en;
    if0.gpio_led = g;
  endtask

  int unsigned rel, rel2, rel3, c;

  initial begin
    reset = 1'b1;
    set_led(1'b1, 1'b1, 3'b000);
    if1.curren = 1'b0; if1.rgbleden = 1'b0; if1.gpio_led = 3'b111;
    if2.curren = 1'b1; if2.rgbleden = 1'b1; if2.gpio_led = 3'b000;

    // Reset state, with LED inputs asking for all channels lit.
    for (int unsigned k = 2; k <= 3; k++) begin
      expect_at(k, D0_RST, 12'd1);
      expect_at(k, D0_CLK, 12'd0);
      expect_at(k, D0_EN,  12'd0);
      expect_at(k, D0_RGB, 12'h007);
      expect_at(k, D0_MA,  12'h000);
      expect_at(k, D2_RGB, 12'h007);
    end

    goto(4);
    rel = cyc;
    for (int unsigned k = 1; k <= 9; k++) begin
      expect_at(rel + k, D0_CLK, (k % 3 == 0) ? 12'd1 : 12'd0);
      expect_at(rel + k, D0_EN,  (k % 3 == 0) ? 12'd1 : 12'd0);
      expect_at(rel + k, D1_CLK, (k % 4 == 2 || k % 4 == 3) ? 12'd1 : 12'd0);
      expect_at(rel + k, D1_EN,  (k % 4 == 2) ? 12'd1 : 12'd0);
    end
    expect_at(rel + 1,    D0_RST, 12'd1);
    expect_at(rel + 767,  D0_RST, 12'd1);
    expect_at(rel + 768,  D0_RST, 12'd0);
    expect_at(rel + 1200, D0_RST, 12'd0);
    expect_at(rel + 1768, D0_RST, 12'd0);
    expect_at(rel + 1,    D2_RGB, 12'h002);
    expect_at(rel + 1,    D2_MA,  12'h303);
    expect_at(rel + 20,   D0_RGB, 12'h000);
    expect_at(rel + 20,   D0_MA,  12'h333);
    reset = 1'b0;

    // LED driver: one-clk latency, enables gate every channel.
    goto(rel + 20);
    set_led(1'b1, 1'b1, 3'b010);
    expect_at(rel + 21, D0_RGB, 12'h002);
    expect_at(rel + 21, D0_MA,  12'h303);
    goto(rel + 30);
    set_led(1'b1, 1'b0, 3'b010);
    expect_at(rel + 31, D0_RGB, 12'h007);
    expect_at(rel + 31, D0_MA,  12'h000);
    goto(rel + 40);
    set_led(1'b1, 1'b1, 3'b101);
    expect_at(rel + 41, D0_RGB, 12'h005);
    expect_at(rel + 41, D0_MA,  12'h030);
    goto(rel + 50);
    set_led(1'b0, 1'b1, 3'b000);
    expect_at(rel + 51, D0_RGB, 12'h007);
    goto(rel + 60);
    set_led(1'b1, 1'b1, 3'b000);
    expect_at(rel + 61, D0_RGB, 12'h000);

    // One-clk reset after sys_reset has fallen: immediate return to 1, LEDs forced off.
    c = rel + 1800;
    goto(c);
    reset = 1'b1;
    expect_at(c + 1, D0_RST, 12'd1);
    expect_at(c + 1, D0_RGB, 12'h007);
    expect_at(c + 1, D0_MA,  12'h000);
    expect_at(c + 1, D0_CLK, 12'd0);
    goto(c + 1);
    rel2 = cyc;
    expect_at(rel2 + 2,   D0_RGB, 12'h000);
    expect_at(rel2 + 299, D0_RST, 12'd1);
    reset = 1'b0;

    // Mid-count reset restarts divider and stretcher from zero.
    goto(rel2 + 299);
    reset = 1'b1;
    expect_at(rel2 + 300, D0_RST, 12'd1);
    goto(rel2 + 300);
    rel3 = cyc;
    expect_at(rel3 + 1,   D0_CLK, 12'd0);
    expect_at(rel3 + 2,   D0_CLK, 12'd0);
    expect_at(rel3 + 3,   D0_CLK, 12'd1);
    expect_at(rel3 + 1,   D1_CLK, 12'd0);
    expect_at(rel3 + 2,   D1_CLK, 12'd1);
    expect_at(rel3 + 2,   D1_EN,  12'd1);
    expect_at(rel3 + 3,   D1_EN,  12'd0);
    expect_at(rel3 + 767, D0_RST, 12'd1);
    expect_at(rel3 + 768, D0_RST, 12'd0);
    reset = 1'b0;

    goto(rel3 + 775);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL %s never checked (tagged cyc=%0d)", e.id.name(), e.cyc);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
